// File: rtl/diag_func_master.sv
// Diagnostic bus master: sequences one function command onto DIAG/DIAG_STROBE/DIAG_READ and EBUS.
// Optional read parity check enabled by defining DIAG_PARITY_CHK_EN.
module diag_func_master #(
    parameter int SETTLE_CYC = 4,
    parameter int STROBE_CYC = 2,
    parameter int READ_CYC   = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [0:6]  cmd_func,
    input  logic [0:35] cmd_wdata,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [0:6]  rsp_func,
    output logic [0:35] rsp_rdata,
    output logic        rsp_perr,
    output logic [0:6]  DIAG,
    output logic        DIAG_STROBE,
    output logic        DIAG_READ,
    output logic [0:35] ebus_dout,
    output logic        ebus_oe,
    input  logic [0:35] ebus_din,
    input  logic        ebus_par_in
);

    typedef enum logic [2:0] {S_IDLE, S_SETUP, S_STROBE, S_HOLD, S_READ, S_RESP} state_t;

    state_t      state_q, state_d;
    logic [7:0]  cnt_q, cnt_d;
    logic [0:6]  func_q, func_d;
    logic [0:35] wdata_q, wdata_d;
    logic [0:6]  diag_q, diag_d;
    logic        strobe_q, strobe_d, read_q, read_d, oe_q, oe_d;
    logic [0:35] dout_q, dout_d;
    logic        rsp_valid_q, rsp_valid_d, perr_q, perr_d;
    logic [0:35] rdata_q, rdata_d;
    logic [0:6]  rsp_func_q, rsp_func_d;
    logic        cnt_last, load_d, cap_perr;

`ifdef DIAG_PARITY_CHK_EN
    // Odd parity over data plus parity bit; an even total is an error.
    assign cap_perr = ~(^ebus_din ^ ebus_par_in);
`else
    logic unused_par;
    assign unused_par = ebus_par_in;
    assign cap_perr   = 1'b0;
`endif

    assign cnt_last  = (cnt_q == 8'd1);
    assign cmd_ready = (state_q == S_IDLE);

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        func_d     = func_q;
        wdata_d    = wdata_q;
        rdata_d    = rdata_q;
        perr_d     = perr_q;
        rsp_func_d = rsp_func_q;
        case (state_q)
            S_IDLE: if (cmd_valid) begin
                state_d = S_SETUP;
                cnt_d   = 8'(SETTLE_CYC);
                func_d  = cmd_func;
                wdata_d = cmd_wdata;
            end
            S_SETUP: if (cnt_last) begin
                if (func_q[0]) begin
                    state_d = S_READ;
                    cnt_d   = 8'(READ_CYC);
                end else begin
                    state_d = S_STROBE;
                    cnt_d   = 8'(STROBE_CYC);
                end
            end else cnt_d = cnt_q - 8'd1;
            S_STROBE: if (cnt_last) state_d = S_HOLD;
                      else cnt_d = cnt_q - 8'd1;
            S_HOLD: begin
                state_d    = S_RESP;
                rdata_d    = '0;
                perr_d     = 1'b0;
                rsp_func_d = func_q;
            end
            S_READ: if (cnt_last) begin
                state_d    = S_RESP;
                rdata_d    = ebus_din;
                perr_d     = cap_perr;
                rsp_func_d = func_q;
            end else cnt_d = cnt_q - 8'd1;
            S_RESP: if (rsp_ready) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        // Bus outputs are decoded from the next state so they come straight off flops.
        load_d      = !func_d[0] && (func_d[1:3] != 3'b000);
        diag_d      = (state_d inside {S_SETUP, S_STROBE, S_HOLD, S_READ}) ? func_d : '0;
        strobe_d    = (state_d == S_STROBE);
        read_d      = (state_d == S_READ);
        oe_d        = load_d && (state_d inside {S_SETUP, S_STROBE, S_HOLD});
        dout_d      = oe_d ? wdata_d : '0;
        rsp_valid_d = (state_d == S_RESP);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            func_q      <= '0;
            wdata_q     <= '0;
            diag_q      <= '0;
            strobe_q    <= 1'b0;
            read_q      <= 1'b0;
            oe_q        <= 1'b0;
            dout_q      <= '0;
            rsp_valid_q <= 1'b0;
            perr_q      <= 1'b0;
            rdata_q     <= '0;
            rsp_func_q  <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            func_q      <= func_d;
            wdata_q     <= wdata_d;
            diag_q      <= diag_d;
            strobe_q    <= strobe_d;
            read_q      <= read_d;
            oe_q        <= oe_d;
            dout_q      <= dout_d;
            rsp_valid_q <= rsp_valid_d;
            perr_q      <= perr_d;
            rdata_q     <= rdata_d;
            rsp_func_q  <= rsp_func_d;
        end
    end

    assign DIAG        = diag_q;
    assign DIAG_STROBE = strobe_q;
    assign DIAG_READ   = read_q;
    assign ebus_oe     = oe_q;
    assign ebus_dout   = dout_q;
    assign rsp_valid   = rsp_valid_q;
    assign rsp_perr    = perr_q;
    assign rsp_rdata   = rdata_q;
    assign rsp_func    = rsp_func_q;

endmodule

// File: tb/tb_diag_func_master.sv
// Scoreboard bench for diag_func_master: per-cycle bus sequencing plus queued response checks.
module tb_diag_func_master;

    localparam int S = 4, T = 2, R = 4;

    logic        clk = 1'b0, rst_n = 1'b0;
    logic        cmd_valid = 1'b0, cmd_ready, rsp_valid, rsp_ready = 1'b0;
    logic [0:6]  cmd_func = '0, rsp_func, DIAG;
    logic [0:35] cmd_wdata = '0, rsp_rdata, ebus_dout, ebus_din = '0;
    logic        rsp_perr, DIAG_STROBE, DIAG_READ, ebus_oe, ebus_par_in = 1'b0;

    typedef struct packed {
        logic [0:6]  f;
        logic [0:35] d;
        logic        p;
    } rsp_t;

    rsp_t sb[$];
    rsp_t mon_e;
    int   vecs = 0, errs = 0;

    always #5 clk = ~clk;

    diag_func_master #(.SETTLE_CYC(S), .STROBE_CYC(T), .READ_CYC(R)) dut (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_func(cmd_func), .cmd_wdata(cmd_wdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_func(rsp_func), .rsp_rdata(rsp_rdata),
        .rsp_perr(rsp_perr), .DIAG(DIAG), .DIAG_STROBE(DIAG_STROBE), .DIAG_READ(DIAG_READ),
        .ebus_dout(ebus_dout), .ebus_oe(ebus_oe), .ebus_din(ebus_din), .ebus_par_in(ebus_par_in)
    );

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        vecs++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    // Response side of the scoreboard: pop on every completed handshake.
    always @(negedge clk) begin
        if (rst_n && rsp_valid && rsp_ready) begin
            if (sb.size() == 0) check("spurious_rsp", 64'(rsp_valid), 64'd0);
            else begin
                mon_e = sb.pop_front();
                check("rsp_func", 64'(rsp_func), 64'(mon_e.f));
                check("rsp_rdata", 64'(rsp_rdata), 64'(mon_e.d));
                check("rsp_perr", 64'(rsp_perr), 64'(mon_e.p));
            end
        end
    end

    // Entered and left at posedge+1.
    task automatic run_cmd(input logic [0:6] f, input logic [0:35] wd, input logic [0:35] din,
                           input logic par, input int hold);
        bit         acc = 0, rd, ld;
        int         n = 0, len;
        rsp_t       e;
        logic [11:0] ev;
        rd = f[0];
        ld = !f[0] && (f[1:3] != 3'b000);
        cmd_valid = 1'b1; cmd_func = f; cmd_wdata = wd;
        ebus_din = din; ebus_par_in = par; rsp_ready = (hold == 0);
        while (!acc && n < 50) begin
            @(negedge clk); acc = cmd_ready;
            @(posedge clk); #1; n++;
        end
        cmd_valid = 1'b0;
        check("accept", 64'(acc), 64'd1);
        if (!acc) return;
        e.f = f;
        e.d = rd ? din : 36'd0;
`ifdef DIAG_PARITY_CHK_EN
        e.p = rd && ((^din ^ par) == 1'b0);
`else
        e.p = 1'b0;
`endif
        sb.push_back(e);
        len = rd ? S + R + 1 : S + T + 2;
        for (int k = 1; k <= len; k++) begin
            @(negedge clk);
            ev = {(k < len) ? f : 7'd0, !rd && k > S && k <= S + T, rd && k > S && k <= S + R,
                  ld && k < len, k == len, 1'b0};
            check($sformatf("f%o_cyc%0d", f, k),
                  64'({DIAG, DIAG_STROBE, DIAG_READ, ebus_oe, rsp_valid, cmd_ready}), 64'(ev));
            if (ld && k < len) check("ebus_dout", 64'(ebus_dout), 64'(wd));
            if (k < len) begin @(posedge clk); #1; end
        end
        for (int h = 0; h < hold; h++) begin
            @(posedge clk); #1;
            cmd_valid = 1'b1; cmd_func = 7'o003;
            @(negedge clk);
            check("bp_hold", 64'({rsp_valid, cmd_ready, rsp_func, rsp_rdata}),
                  64'({1'b1, 1'b0, e.f, e.d}));
        end
        if (hold > 0) begin
            @(posedge clk); #1;
            rsp_ready = 1'b1; cmd_valid = 1'b0;
            @(negedge clk);
        end
        @(posedge clk); #1;
        @(negedge clk);
        check("idle_after", 64'({cmd_ready, rsp_valid}), 64'({1'b1, 1'b0}));
        @(posedge clk); #1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        logic [0:6]  rf;
        logic [0:35] rw, rdin;
        #12;
        check("reset_state", 64'({cmd_ready, rsp_valid, DIAG_STROBE, DIAG_READ, ebus_oe, rsp_perr,
                                  DIAG, ebus_dout}), 64'({1'b1, 5'b0, 7'd0, 36'd0}));
        check("reset_rsp", 64'({rsp_func, rsp_rdata}), 64'd0);
        @(posedge clk); #1; rst_n = 1'b1;
        @(posedge clk); #1;

        run_cmd(7'o042, 36'o123456701234, 36'd0, 1'b0, 0);
        run_cmd(7'o123, 36'd0, 36'o777000111222, 1'b0, 0);
        run_cmd(7'o001, 36'o555555555555, 36'o111111111111, 1'b0, 0);
        run_cmd(7'o007, 36'd0, 36'd0, 1'b0, 0);
        run_cmd(7'o010, 36'o777777777777, 36'd0, 1'b0, 0);
        run_cmd(7'o077, 36'o000000000001, 36'd0, 1'b0, 0);
        run_cmd(7'o100, 36'd0, 36'o400000000000, 1'b1, 0);
        run_cmd(7'o177, 36'd0, 36'o777777777777, 1'b1, 0);
        run_cmd(7'o055, 36'o246135702461, 36'd0, 1'b0, 10);
        run_cmd(7'o003, 36'd0, 36'd0, 1'b0, 0);
        run_cmd(7'o150, 36'd0, 36'd0, 1'b0, 0);
        run_cmd(7'o150, 36'd0, 36'd0, 1'b1, 0);

        for (int i = 0; i < 4; i++) begin
            rf = 7'($urandom_range(0, 127));
            rw = {4'($urandom), 32'($urandom)};
            rdin = {4'($urandom), 32'($urandom)};
            run_cmd(rf, rw, rdin, 1'($urandom), 0);
        end

        // Async reset in the middle of a LOAD strobe: no response may follow.
        cmd_valid = 1'b1; cmd_func = 7'o042; cmd_wdata = 36'o123456701234; rsp_ready = 1'b1;
        @(negedge clk);
        check("rst_accept_ready", 64'(cmd_ready), 64'd1);
        @(posedge clk); #1; cmd_valid = 1'b0;
        repeat (S) @(posedge clk);
        #3;
        check("rst_pre_strobe", 64'({DIAG_STROBE, ebus_oe}), 64'({1'b1, 1'b1}));
        rst_n = 1'b0;
        #1;
        check("rst_async", 64'({DIAG, DIAG_STROBE, ebus_oe, rsp_valid, cmd_ready}),
              64'({7'd0, 1'b0, 1'b0, 1'b0, 1'b1}));
        @(posedge clk); #1; rst_n = 1'b1;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            check("rst_no_rsp", 64'({rsp_valid, cmd_ready}), 64'({1'b0, 1'b1}));
        end
        @(posedge clk); #1;
        run_cmd(7'o123, 36'd0, 36'o012345670123, 1'b0, 0);

        check("sb_drained", 64'(sb.size()), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
